// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-channel cache fill controller.
// Combinational only; no latency, no backpressure.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TAG
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_WORDS  = 8;
    localparam int DEF_NCH    = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_fill_word_counter.sv
// Word counter with synchronous clear that saturates at WORDS; count visible the cycle after inc.
// No backpressure: increments beyond WORDS are dropped and done stays high.
module fill_word_counter #(
    parameter int CNT_W = 4,
    parameter int WORDS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WORDS);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = (r_cnt == LIMIT);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Fixed-priority multi-channel miss fill: first read one cycle after grant, tag pulse one cycle after last word.
// Losing channels see fsm_busy held high until granted; memory returns are never throttled.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORDS  = DEF_WORDS,
    parameter int NCH    = DEF_NCH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          miss_detected,
    input  logic [NCH*ADDR_W-1:0]   miss_address,
    input  logic                    memory_data_valid,
    output logic                    mem_read_en,
    output logic [ADDR_W-1:0]       memory_address,
    output logic [NCH-1:0]          fsm_busy,
    output logic [NCH-1:0]          write_data_array,
    output logic [NCH-1:0]          write_tag_array,
    output logic [clog2(WORDS)-1:0] fill_word_idx,
    output logic [ADDR_W-1:0]       fill_address
);

    localparam int WORD_BYTES = DATA_W / 8;
    localparam int OFF_W      = clog2(WORDS * WORD_BYTES);
    localparam int IDX_W      = clog2(WORDS);
    localparam int CNT_W      = IDX_W + 1;
    localparam int BYTE_SH    = clog2(WORD_BYTES);
    localparam int OWN_W      = (NCH > 1) ? clog2(NCH) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    state_t            r_state;
    logic [OWN_W-1:0]  r_owner;
    logic [ADDR_W-1:0] r_base;

    logic [OWN_W-1:0]  w_grant;
    logic [ADDR_W-1:0] w_req_addr;
    logic [CNT_W-1:0]  w_issue_cnt;
    logic [CNT_W-1:0]  w_rsp_cnt;
    logic              w_issue_done;
    logic              w_rsp_done;
    logic              w_start;
    logic              w_issue;
    logic              w_accept;
    logic              w_last;

    // Lowest set index wins, so iterate from the top down.
    always_comb begin
        w_grant = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (miss_detected[i]) begin
                w_grant = OWN_W'(i);
            end
        end
    end

    assign w_req_addr = miss_address[int'(w_grant) * ADDR_W +: ADDR_W];
    assign w_start    = (r_state == IDLE) && (|miss_detected);
    assign w_issue    = (r_state == FILL) && !w_issue_done;
    assign w_accept   = (r_state == FILL) && memory_data_valid && !w_rsp_done;
    assign w_last     = w_accept && (w_rsp_cnt == CNT_W'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_owner <= w_grant;
                        r_base  <= w_req_addr & ~OFF_MASK;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_last) begin
                        r_state <= TAG;
                    end
                end
                TAG:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    fill_word_counter #(.CNT_W(CNT_W), .WORDS(WORDS)) u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start),
        .i_inc   (w_issue),
        .o_cnt   (w_issue_cnt),
        .o_done  (w_issue_done)
    );

    fill_word_counter #(.CNT_W(CNT_W), .WORDS(WORDS)) u_rsp_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start),
        .i_inc   (w_accept),
        .o_cnt   (w_rsp_cnt),
        .o_done  (w_rsp_done)
    );

    always_comb begin
        mem_read_en      = w_issue;
        memory_address   = w_issue ? (r_base | (ADDR_W'(w_issue_cnt) << BYTE_SH)) : '0;
        fill_word_idx    = w_accept ? w_rsp_cnt[IDX_W-1:0] : '0;
        fill_address     = r_base;
        write_data_array = '0;
        write_tag_array  = '0;
        fsm_busy         = miss_detected;
        for (int i = 0; i < NCH; i++) begin
            if (r_owner == OWN_W'(i)) begin
                write_data_array[i] = w_accept;
                write_tag_array[i]  = (r_state == TAG);
                fsm_busy[i]         = miss_detected[i] | (r_state != IDLE);
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: pipelined memory model with random latency and an event-log scoreboard.
module tb_cache_fill_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS  = 8;
    localparam int NCH    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NCH-1:0]        miss_detected = '0;
    logic [NCH*ADDR_W-1:0] miss_address = '0;
    logic                  memory_data_valid = 1'b0;
    logic                  mem_read_en;
    logic [ADDR_W-1:0]     memory_address;
    logic [NCH-1:0]        fsm_busy;
    logic [NCH-1:0]        write_data_array;
    logic [NCH-1:0]        write_tag_array;
    logic [2:0]            fill_word_idx;
    logic [ADDR_W-1:0]     fill_address;

    cache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .NCH(NCH)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .fill_word_idx     (fill_word_idx),
        .fill_address      (fill_address)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [NCH-1:0]    req = '0;
    logic [ADDR_W-1:0] req_addr [NCH];

    int  due_q[$];
    int  lat_lo = 4;
    int  lat_hi = 4;
    bit  force_vld = 1'b0;
    bit  extra_at_tag = 1'b0;
    int  extra_cyc = -1;
    int  ret_cnt = 0;

    int                iss_cyc_q[$];
    logic [ADDR_W-1:0] iss_addr_q[$];
    int                wr_cyc_q[$];
    int                wr_ch_q[$];
    int                wr_idx_q[$];
    int                tag_cyc_q[$];
    int                tag_ch_q[$];

    logic [ADDR_W-1:0] pf_addr [WORDS];
    int                pf_icyc [WORDS];
    int                pf_wch  [WORDS];
    int                pf_widx [WORDS];
    int                pf_wcyc [WORDS];
    int                pf_tch;
    int                pf_tcyc;

    task automatic clear_logs();
        due_q.delete(); iss_cyc_q.delete(); iss_addr_q.delete();
        wr_cyc_q.delete(); wr_ch_q.delete(); wr_idx_q.delete();
        tag_cyc_q.delete(); tag_ch_q.delete();
        ret_cnt = 0;
        extra_cyc = -1;
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, log what the DUT did.
    task automatic step();
        bit ret;
        int d;
        @(negedge clk);
        ret = (due_q.size() > 0) && (due_q[0] == cyc);
        if (ret) begin
            void'(due_q.pop_front());
            ret_cnt++;
            if (extra_at_tag && (ret_cnt % WORDS == 0)) extra_cyc = cyc + 1;
        end
        memory_data_valid = ret || force_vld || (cyc == extra_cyc);
        miss_detected = req;
        for (int i = 0; i < NCH; i++) miss_address[i*ADDR_W +: ADDR_W] = req_addr[i];
        #1;
        n_chk++;
        if (fsm_busy !== req) begin
            n_fail++;
            $display("FAIL busy cyc %0d: got %b want %b", cyc, fsm_busy, req);
        end
        if (mem_read_en === 1'b1) begin
            iss_cyc_q.push_back(cyc);
            iss_addr_q.push_back(memory_address);
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
            due_q.push_back(d);
        end
        for (int i = 0; i < NCH; i++) begin
            if (write_data_array[i] === 1'b1) begin
                wr_cyc_q.push_back(cyc); wr_ch_q.push_back(i); wr_idx_q.push_back(int'(fill_word_idx));
            end
            if (write_tag_array[i] === 1'b1) begin
                tag_cyc_q.push_back(cyc); tag_ch_q.push_back(i);
                req[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic run_until(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (tag_cyc_q.size() < n && k < budget) begin
            step();
            k++;
        end
        n_chk++;
        if (tag_cyc_q.size() < n) begin
            n_fail++;
            $display("FAIL %s timeout: tags %0d want %0d", nm, tag_cyc_q.size(), n);
        end
        step();
        step();
    endtask

    // Moves one block's worth of logged events into the pf_* slots; missing events become X / -1.
    task automatic pop_fill();
        for (int k = 0; k < WORDS; k++) begin
            pf_addr[k] = (iss_addr_q.size() > 0) ? iss_addr_q.pop_front() : 'x;
            pf_icyc[k] = (iss_cyc_q.size() > 0) ? iss_cyc_q.pop_front() : -1;
            pf_wch[k]  = (wr_ch_q.size() > 0) ? wr_ch_q.pop_front() : -1;
            pf_widx[k] = (wr_idx_q.size() > 0) ? wr_idx_q.pop_front() : -1;
            pf_wcyc[k] = (wr_cyc_q.size() > 0) ? wr_cyc_q.pop_front() : -1;
        end
        pf_tch  = (tag_ch_q.size() > 0) ? tag_ch_q.pop_front() : -1;
        pf_tcyc = (tag_cyc_q.size() > 0) ? tag_cyc_q.pop_front() : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (mem_read_en !== 1'b0 || memory_address !== '0) begin
            n_fail++; $display("FAIL reset read: got en=%b addr=%h want 0", mem_read_en, memory_address);
        end
        n_chk++;
        if (fsm_busy !== '0 || write_data_array !== '0 || write_tag_array !== '0) begin
            n_fail++; $display("FAIL reset enables: got busy=%b wda=%b wta=%b want 0", fsm_busy, write_data_array, write_tag_array);
        end
        n_chk++;
        if (fill_word_idx !== '0 || fill_address !== '0) begin
            n_fail++; $display("FAIL reset fill: got idx=%0d addr=%h want 0", fill_word_idx, fill_address);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int m;
        logic [ADDR_W-1:0] e;
        clear_logs();
        lat_lo = 4; lat_hi = 4;
        req_addr[0] = 16'h1236;
        m = cyc;
        req[0] = 1'b1;
        run_until(1, 100, "single");
        pop_fill();
        for (int k = 0; k < WORDS; k++) begin
            e = 16'h1230 + ADDR_W'(2 * k);
            n_chk++;
            if (pf_addr[k] !== e || pf_icyc[k] != m + 1 + k) begin
                n_fail++; $display("FAIL single issue %0d: got %h@%0d want %h@%0d", k, pf_addr[k], pf_icyc[k], e, m + 1 + k);
            end
            n_chk++;
            if (pf_wch[k] != 0 || pf_widx[k] != k || pf_wcyc[k] != m + 5 + k) begin
                n_fail++; $display("FAIL single write %0d: got ch%0d idx%0d @%0d want ch0 idx%0d @%0d", k, pf_wch[k], pf_widx[k], pf_wcyc[k], k, m + 5 + k);
            end
        end
        n_chk++;
        if (pf_tch != 0 || pf_tcyc != m + 5 + WORDS) begin
            n_fail++; $display("FAIL single tag: got ch%0d @%0d want ch0 @%0d", pf_tch, pf_tcyc, m + 5 + WORDS);
        end
        n_chk++;
        if (wr_cyc_q.size() != 0 || iss_cyc_q.size() != 0 || tag_cyc_q.size() != 0) begin
            n_fail++; $display("FAIL single leftovers: got wr=%0d iss=%0d tag=%0d want 0", wr_cyc_q.size(), iss_cyc_q.size(), tag_cyc_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        logic [ADDR_W-1:0] e;
        clear_logs();
        req_addr[0] = 16'h2000;
        req_addr[1] = 16'h8010;
        req = 2'b11;
        run_until(2, 200, "simul");
        pop_fill();
        t0 = pf_tcyc;
        for (int k = 0; k < WORDS; k++) begin
            e = 16'h2000 + ADDR_W'(2 * k);
            n_chk++;
            if (pf_addr[k] !== e || pf_wch[k] != 0 || pf_widx[k] != k) begin
                n_fail++; $display("FAIL simul ch0 %0d: got %h ch%0d idx%0d want %h ch0 idx%0d", k, pf_addr[k], pf_wch[k], pf_widx[k], e, k);
            end
        end
        n_chk++;
        if (pf_tch != 0 || t0 != pf_wcyc[WORDS-1] + 1) begin
            n_fail++; $display("FAIL simul tag0: got ch%0d @%0d want ch0 @%0d", pf_tch, t0, pf_wcyc[WORDS-1] + 1);
        end
        pop_fill();
        n_chk++;
        if (pf_icyc[0] != t0 + 2) begin
            n_fail++; $display("FAIL simul ch1 start: got %0d want %0d", pf_icyc[0], t0 + 2);
        end
        for (int k = 0; k < WORDS; k++) begin
            e = 16'h8010 + ADDR_W'(2 * k);
            n_chk++;
            if (pf_addr[k] !== e || pf_wch[k] != 1 || pf_widx[k] != k) begin
                n_fail++; $display("FAIL simul ch1 %0d: got %h ch%0d idx%0d want %h ch1 idx%0d", k, pf_addr[k], pf_wch[k], pf_widx[k], e, k);
            end
        end
        n_chk++;
        if (pf_tch != 1 || pf_tcyc != pf_wcyc[WORDS-1] + 1) begin
            n_fail++; $display("FAIL simul tag1: got ch%0d @%0d want ch1 @%0d", pf_tch, pf_tcyc, pf_wcyc[WORDS-1] + 1);
        end
    endtask

    task automatic test_spurious_extra();
        clear_logs();
        force_vld = 1'b1;
        repeat (4) step();
        force_vld = 1'b0;
        n_chk++;
        if (wr_cyc_q.size() != 0 || iss_cyc_q.size() != 0 || tag_cyc_q.size() != 0) begin
            n_fail++; $display("FAIL idle valid: got wr=%0d iss=%0d tag=%0d want 0", wr_cyc_q.size(), iss_cyc_q.size(), tag_cyc_q.size());
        end
        clear_logs();
        extra_at_tag = 1'b1;
        req_addr[0] = 16'h3456;
        req[0] = 1'b1;
        run_until(1, 100, "extra");
        extra_at_tag = 1'b0;
        pop_fill();
        for (int k = 0; k < WORDS; k++) begin
            n_chk++;
            if (pf_wch[k] != 0 || pf_widx[k] != k) begin
                n_fail++; $display("FAIL extra write %0d: got ch%0d idx%0d want ch0 idx%0d", k, pf_wch[k], pf_widx[k], k);
            end
        end
        n_chk++;
        if (wr_cyc_q.size() != 0) begin
            n_fail++; $display("FAIL extra ninth write: got %0d extra writes want 0", wr_cyc_q.size());
        end
        n_chk++;
        if (pf_tcyc != pf_wcyc[WORDS-1] + 1 || pf_addr[0] !== 16'h3450) begin
            n_fail++; $display("FAIL extra tag/base: got @%0d %h want @%0d 3450", pf_tcyc, pf_addr[0], pf_wcyc[WORDS-1] + 1);
        end
    endtask

    task automatic test_variable_latency();
        int ch;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] e;
        for (int n = 0; n < 6; n++) begin
            clear_logs();
            lat_lo = 1;
            lat_hi = (n == 0) ? 1 : 10;
            ch = int'($urandom_range(1, 0));
            a = ADDR_W'($urandom);
            req_addr[ch] = a;
            req[ch] = 1'b1;
            run_until(1, 300, "varlat");
            pop_fill();
            for (int k = 0; k < WORDS; k++) begin
                e = (a & 16'hFFF0) + ADDR_W'(2 * k);
                n_chk++;
                if (pf_addr[k] !== e || pf_wch[k] != ch || pf_widx[k] != k) begin
                    n_fail++; $display("FAIL varlat %0d/%0d: got %h ch%0d idx%0d want %h ch%0d idx%0d", n, k, pf_addr[k], pf_wch[k], pf_widx[k], e, ch, k);
                end
            end
            n_chk++;
            if (wr_cyc_q.size() != 0 || pf_tch != ch || pf_tcyc != pf_wcyc[WORDS-1] + 1) begin
                n_fail++; $display("FAIL varlat %0d tag: got ch%0d @%0d extra=%0d want ch%0d @%0d", n, pf_tch, pf_tcyc, wr_cyc_q.size(), ch, pf_wcyc[WORDS-1] + 1);
            end
        end
        lat_lo = 4; lat_hi = 4;
    endtask

    task automatic test_addr_change();
        logic [ADDR_W-1:0] e;
        clear_logs();
        req_addr[0] = 16'h5A5C;
        req[0] = 1'b1;
        repeat (4) step();
        req_addr[0] = 16'hC3F7;
        repeat (3) begin
            step();
            n_chk++;
            if (fill_address !== 16'h5A50) begin
                n_fail++; $display("FAIL addrchg fill_address: got %h want 5a50", fill_address);
            end
        end
        run_until(1, 100, "addrchg");
        pop_fill();
        for (int k = 0; k < WORDS; k++) begin
            e = 16'h5A50 + ADDR_W'(2 * k);
            n_chk++;
            if (pf_addr[k] !== e) begin
                n_fail++; $display("FAIL addrchg issue %0d: got %h want %h", k, pf_addr[k], e);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int k;
        logic [ADDR_W-1:0] e;
        clear_logs();
        req_addr[0] = 16'h7770;
        req[0] = 1'b1;
        k = 0;
        while (wr_cyc_q.size() < 3 && k < 50) begin
            step();
            k++;
        end
        n_chk++;
        if (wr_cyc_q.size() != 3) begin
            n_fail++; $display("FAIL rstmid setup: got %0d writes want 3", wr_cyc_q.size());
        end
        req = '0;
        miss_detected = '0;
        memory_data_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++;
        if (mem_read_en !== 1'b0 || memory_address !== '0 || fill_address !== '0) begin
            n_fail++; $display("FAIL rstmid read: got en=%b addr=%h base=%h want 0", mem_read_en, memory_address, fill_address);
        end
        n_chk++;
        if (fsm_busy !== '0 || write_data_array !== '0 || write_tag_array !== '0 || fill_word_idx !== '0) begin
            n_fail++; $display("FAIL rstmid enables: got busy=%b wda=%b wta=%b idx=%0d want 0", fsm_busy, write_data_array, write_tag_array, fill_word_idx);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (6) step();
        n_chk++;
        if (tag_cyc_q.size() != 0 || wr_cyc_q.size() != 0 || iss_cyc_q.size() != 0) begin
            n_fail++; $display("FAIL rstmid aborted: got tag=%0d wr=%0d iss=%0d want 0", tag_cyc_q.size(), wr_cyc_q.size(), iss_cyc_q.size());
        end
        req_addr[1] = 16'h0040;
        req[1] = 1'b1;
        run_until(1, 100, "rstmid");
        pop_fill();
        for (int j = 0; j < WORDS; j++) begin
            e = 16'h0040 + ADDR_W'(2 * j);
            n_chk++;
            if (pf_addr[j] !== e || pf_wch[j] != 1 || pf_widx[j] != j) begin
                n_fail++; $display("FAIL rstmid refill %0d: got %h ch%0d idx%0d want %h ch1 idx%0d", j, pf_addr[j], pf_wch[j], pf_widx[j], e, j);
            end
        end
        n_chk++;
        if (pf_tch != 1) begin
            n_fail++; $display("FAIL rstmid tag: got ch%0d want ch1", pf_tch);
        end
    endtask

    initial begin
        req_addr[0] = '0;
        req_addr[1] = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_spurious_extra();
        test_variable_latency();
        test_addr_change();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
